// File: rtl/snd_ports_fifo.sv
// Z80-side sound ports: volume and sample writes are queued in a
// first-word fall-through FIFO and drained over valid/ready.
module snd_ports_fifo #(
  parameter int         CHANS      = 8,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [5:0] VOL_BASE   = 6'h20,
  parameter logic [5:0] STAT_PORT  = 6'h1F,
  localparam int AW = $clog2(CHANS),
  localparam int LW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          cpu_clock,
  input  logic          rst_n,
  input  logic [15:0]   a,
  input  logic [7:0]    din,
  output logic [7:0]    dout,
  output logic          busin,
  input  logic          iorq_n,
  input  logic          mreq_n,
  input  logic          rd_n,
  input  logic          wr_n,
  input  logic          mode_full,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_datnvol,
  output logic [AW-1:0] out_addr,
  output logic [7:0]    out_data,
  output logic [LW-1:0] fifo_level,
  output logic          overflow
);

  localparam int PW = LW - 1;
  localparam int EW = 1 + AW + 8;

  logic          r_iowr_prev;
  logic          r_memrd_prev;
  logic [EW-1:0] r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wptr;
  logic [PW-1:0] r_rptr;
  logic [LW-1:0] r_level;
  logic          r_ovf;

  logic          w_iowr_stb;
  logic          w_memrd_stb;
  logic          w_win;
  logic [5:0]    w_port;
  logic [5:0]    w_voff;
  logic          w_vol_hit;
  logic          w_vol_en;
  logic          w_vol_push;
  logic          w_smp_push;
  logic          w_stat_wr;
  logic          w_flush;
  logic          w_clr;
  logic [AW-1:0] w_sch;
  logic          w_push_req;
  logic [EW-1:0] w_push_ent;
  logic          w_full;
  logic          w_empty;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [EW-1:0] w_head;

  assign w_iowr_stb  = ~(iorq_n | wr_n) & r_iowr_prev;
  assign w_memrd_stb = ~(mreq_n | rd_n) & r_memrd_prev;

  assign w_win  = a[7:6] == 2'b00;
  assign w_port = a[5:0];
  assign w_voff = w_port - VOL_BASE;

  assign w_vol_hit = w_win && (w_port >= VOL_BASE)
                     && (w_voff < 6'(CHANS));
  assign w_vol_en  = mode_full || (w_voff < 6'(CHANS / 2));
  assign w_vol_push = w_iowr_stb && w_vol_hit && w_vol_en;

  assign w_smp_push = w_memrd_stb && (a[15:13] == 3'b011);

  assign w_stat_wr = w_iowr_stb && w_win && (w_port == STAT_PORT);
  assign w_flush   = w_stat_wr && din[6];
  assign w_clr     = w_stat_wr && din[7];

  // Half mode folds the upper channel bank onto the lower one
  always_comb begin
    w_sch = a[8 +: AW];
    w_sch[AW-1] = a[8+AW-1] & mode_full;
  end

  assign w_push_req = w_vol_push || w_smp_push;
  assign w_push_ent = w_smp_push ? {1'b1, w_sch, din}
                                 : {1'b0, w_voff[AW-1:0], din};

  assign w_full  = r_level == LW'(FIFO_DEPTH);
  assign w_empty = r_level == '0;
  assign w_pop   = !w_empty && out_ready;
  assign w_push  = w_push_req && (!w_full || w_pop) && !w_flush;

  // A colliding io write loses to the mem strobe and counts as a drop
  assign w_drop = (w_push_req && w_full && !w_pop && !w_flush)
                  || (w_vol_push && w_smp_push);

  always_ff @(posedge cpu_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_iowr_prev  <= 1'b1;
      r_memrd_prev <= 1'b1;
      r_wptr       <= '0;
      r_rptr       <= '0;
      r_level      <= '0;
      r_ovf        <= 1'b0;
    end else begin
      r_iowr_prev  <= iorq_n | wr_n;
      r_memrd_prev <= mreq_n | rd_n;
      if (w_flush) begin
        r_wptr  <= '0;
        r_rptr  <= '0;
        r_level <= '0;
      end else begin
        if (w_push)
          r_wptr <= r_wptr + PW'(1);
        if (w_pop)
          r_rptr <= r_rptr + PW'(1);
        if (w_push && !w_pop)
          r_level <= r_level + LW'(1);
        else if (!w_push && w_pop)
          r_level <= r_level - LW'(1);
      end
      if (w_drop)
        r_ovf <= 1'b1;
      else if (w_clr)
        r_ovf <= 1'b0;
    end
  end

  always_ff @(posedge cpu_clock) begin
    if (w_push)
      r_mem[r_wptr] <= w_push_ent;
  end

  assign w_head = w_empty ? '0 : r_mem[r_rptr];

  assign out_valid   = !w_empty;
  assign out_datnvol = w_head[EW-1];
  assign out_addr    = w_head[8 +: AW];
  assign out_data    = w_head[7:0];
  assign fifo_level  = r_level;
  assign overflow    = r_ovf;

  assign dout  = {r_ovf, w_full, w_empty, 5'(r_level)};
  assign busin = ~(w_win & ~iorq_n & ~rd_n
                   & (w_port == STAT_PORT));

endmodule

// File: tb/tb_snd_ports_fifo.sv
// Bench for snd_ports_fifo: directed scenarios plus random Z80
// accesses checked against a queue-based reference model.
`timescale 1ns/1ps
module tb_snd_ports_fifo;

  localparam int         CH  = 8;
  localparam int         DEP = 4;
  localparam int         AW  = 3;
  localparam int         LW  = 3;
  localparam logic [5:0] VB  = 6'h20;
  localparam logic [5:0] SP  = 6'h1F;

  localparam int K_NONE  = 0;
  localparam int K_IOWR  = 1;
  localparam int K_IORD  = 2;
  localparam int K_MEMRD = 3;
  localparam int K_MEMWR = 4;
  localparam int K_COLL  = 5;

  logic          cpu_clock = 1'b0;
  logic          rst_n     = 1'b0;
  logic [15:0]   a         = '0;
  logic [7:0]    din       = '0;
  logic          iorq_n    = 1'b1;
  logic          mreq_n    = 1'b1;
  logic          rd_n      = 1'b1;
  logic          wr_n      = 1'b1;
  logic          mode_full = 1'b1;
  logic          out_ready = 1'b0;
  logic [7:0]    dout;
  logic          busin;
  logic          out_valid;
  logic          out_datnvol;
  logic [AW-1:0] out_addr;
  logic [7:0]    out_data;
  logic [LW-1:0] fifo_level;
  logic          overflow;

  snd_ports_fifo #(
    .CHANS(CH), .FIFO_DEPTH(DEP),
    .VOL_BASE(VB), .STAT_PORT(SP)
  ) dut (
    .cpu_clock(cpu_clock), .rst_n(rst_n),
    .a(a), .din(din), .dout(dout), .busin(busin),
    .iorq_n(iorq_n), .mreq_n(mreq_n),
    .rd_n(rd_n), .wr_n(wr_n),
    .mode_full(mode_full),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_datnvol(out_datnvol), .out_addr(out_addr),
    .out_data(out_data), .fifo_level(fifo_level),
    .overflow(overflow)
  );

  always #5 cpu_clock = ~cpu_clock;

  int          total = 0;
  int          bad   = 0;
  logic [11:0] q[$];
  logic        m_ovf = 1'b0;
  int          cur_kind = K_NONE;
  bit          rnd_ready = 1'b0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    bit rdstat;
    chk("valid", 32'(out_valid), 32'(q.size() != 0));
    chk("level", 32'(fifo_level), 32'(q.size()));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    if (q.size() != 0)
      chk("head", 32'({out_datnvol, out_addr, out_data}), 32'(q[0]));
    rdstat = (cur_kind == K_IORD) && (a[7:6] == 2'b00)
             && (a[5:0] == SP);
    chk("busin", 32'(busin), 32'(!rdstat));
    if (a[5:0] == SP)
      chk("dout", 32'(dout),
          32'({m_ovf, q.size() == DEP, q.size() == 0, 5'(q.size())}));
  endtask

  // One access is one event, applied at its first active edge
  task automatic model_update(input bit first);
    bit          pop, vol, smp, sw, drop;
    logic [5:0]  p;
    int          vi;
    logic [11:0] e_s, e_v;
    p    = a[5:0];
    pop  = (q.size() != 0) && out_ready;
    vol  = 1'b0;
    smp  = 1'b0;
    sw   = 1'b0;
    drop = 1'b0;
    vi   = int'(p) - int'(VB);
    if (first) begin
      if ((cur_kind == K_IOWR || cur_kind == K_COLL) && a[7:6] == 2'b00) begin
        if (p == SP)
          sw = 1'b1;
        else if (vi >= 0 && vi < CH && (mode_full || vi < CH / 2))
          vol = 1'b1;
      end
      if ((cur_kind == K_MEMRD || cur_kind == K_COLL)
          && a[15:13] == 3'b011)
        smp = 1'b1;
    end
    e_v = {1'b0, 3'(vi), din};
    e_s = {1'b1, a[10] & mode_full, a[9:8], din};
    if (sw && din[6]) begin
      q.delete();
      if (din[7]) m_ovf = 1'b0;
      return;
    end
    if (pop) q.delete(0);
    if (vol && smp) drop = 1'b1;
    if (vol || smp) begin
      if (q.size() < DEP) q.push_back(smp ? e_s : e_v);
      else drop = 1'b1;
    end
    if (drop) m_ovf = 1'b1;
    else if (sw && din[7]) m_ovf = 1'b0;
  endtask

  task automatic clk_cycle(input bit first);
    if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
    @(negedge cpu_clock);
    check_outputs();
    @(posedge cpu_clock);
    model_update(first);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) clk_cycle(1'b0);
  endtask

  task automatic access(input int kind, input logic [15:0] addr,
                        input logic [7:0] d, input int len);
    a = addr;
    din = d;
    cur_kind = kind;
    case (kind)
      K_IOWR:  begin iorq_n = 0; wr_n = 0; end
      K_IORD:  begin iorq_n = 0; rd_n = 0; end
      K_MEMRD: begin mreq_n = 0; rd_n = 0; end
      K_MEMWR: begin mreq_n = 0; wr_n = 0; end
      K_COLL:  begin iorq_n = 0; mreq_n = 0; rd_n = 0; wr_n = 0; end
      default: ;
    endcase
    for (int i = 0; i < len; i++) clk_cycle(i == 0);
    iorq_n = 1; mreq_n = 1; rd_n = 1; wr_n = 1;
    cur_kind = K_NONE;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_valid"}, 32'(out_valid), 0);
    chk({tag, "_level"}, 32'(fifo_level), 0);
    chk({tag, "_ovf"}, 32'(overflow), 0);
    chk({tag, "_head"}, 32'({out_datnvol, out_addr, out_data}), 0);
  endtask

  initial begin
    int lvl;
    logic [15:0] ra;
    logic [7:0]  rd;
    int r;

    repeat (3) @(posedge cpu_clock);
    #1;
    check_reset_state("rst");
    @(negedge cpu_clock) rst_n = 1'b1;
    @(posedge cpu_clock);
    #1;

    // Single volume write passes straight through
    out_ready = 1'b1;
    access(K_IOWR, {8'h00, 2'b00, VB + 6'd3}, 8'h40, 1);
    chk("v3_valid", 32'(out_valid), 1);
    chk("v3_dnv", 32'(out_datnvol), 0);
    chk("v3_addr", 32'(out_addr), 3);
    chk("v3_data", 32'(out_data), 8'h40);
    idle(1);
    chk("v3_drain", 32'(fifo_level), 0);

    // Five samples into four slots, then status read and flush
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      access(K_MEMRD, 16'(16'h6000 + i * 16'h0100), 8'(i * 8'h11), 1);
      idle(1);
    end
    chk("ovf_level", 32'(fifo_level), 4);
    chk("ovf_flag", 32'(overflow), 1);
    access(K_IORD, {10'd0, SP}, 8'h00, 1);
    chk("stat_c4", 32'(dout), 8'hC4);
    idle(1);
    access(K_IOWR, {10'd0, SP}, 8'hC0, 1);
    chk("flush_ovf", 32'(overflow), 0);
    chk("flush_lvl", 32'(fifo_level), 0);
    chk("flush_vld", 32'(out_valid), 0);
    idle(1);
    access(K_IORD, {10'd0, SP}, 8'h00, 1);
    chk("stat_20", 32'(dout), 8'h20);
    idle(1);

    // Pop order
    for (int i = 1; i <= 4; i++) begin
      access(K_MEMRD, 16'(16'h6000 + i * 16'h0100), 8'(i * 8'h11), 1);
      idle(1);
    end
    out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      chk("pop_addr", 32'(out_addr), 32'(i));
      chk("pop_data", 32'(out_data), 32'(i * 8'h11));
      clk_cycle(1'b0);
    end
    chk("pop_empty", 32'(fifo_level), 0);

    // Full FIFO: push with a simultaneous pop is accepted
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      access(K_IOWR, {10'd0, 6'(VB + 6'(i))}, 8'(8'hA0 + i), 1);
      idle(1);
    end
    out_ready = 1'b1;
    access(K_MEMRD, 16'h6500, 8'h55, 1);
    chk("fp_level", 32'(fifo_level), 4);
    chk("fp_ovf", 32'(overflow), 0);
    idle(6);

    // Half mode: upper volume ports ignored, sample channel folded
    mode_full = 1'b0;
    out_ready = 1'b0;
    access(K_IOWR, {10'd0, VB + 6'd5}, 8'h10, 1);
    chk("half_vol", 32'(fifo_level), 0);
    chk("half_ovf", 32'(overflow), 0);
    idle(1);
    access(K_MEMRD, 16'h6700, 8'h77, 1);
    chk("half_addr", 32'(out_addr), 3);
    chk("half_dnv", 32'(out_datnvol), 1);
    idle(1);
    mode_full = 1'b1;
    out_ready = 1'b1;
    idle(2);

    // Colliding io and mem strobes
    out_ready = 1'b0;
    access(K_COLL, 16'h6123, 8'h99, 1);
    chk("coll_lvl", 32'(fifo_level), 1);
    chk("coll_ovf", 32'(overflow), 1);
    chk("coll_addr", 32'(out_addr), 1);
    idle(1);
    access(K_IOWR, {10'd0, SP}, 8'h80, 1);
    chk("clr_ovf", 32'(overflow), 0);
    chk("clr_lvl", 32'(fifo_level), 1);
    idle(1);
    out_ready = 1'b1;
    idle(2);

    // Long write gives one entry; reset drops the queue at once
    out_ready = 1'b0;
    lvl = int'(fifo_level);
    access(K_IOWR, {10'd0, VB + 6'd2}, 8'h22, 3);
    chk("long_wr", 32'(fifo_level), 32'(lvl + 1));
    idle(1);
    access(K_MEMRD, 16'h6200, 8'h5A, 1);
    idle(1);
    rst_n = 1'b0;
    #1;
    check_reset_state("midrst");
    q.delete();
    m_ovf = 1'b0;
    @(negedge cpu_clock) rst_n = 1'b1;
    @(posedge cpu_clock);
    #1;

    // Random traffic
    rnd_ready = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r  = $urandom_range(0, 99);
      rd = 8'($urandom);
      if (r < 30) begin
        ra = {8'($urandom),
              ($urandom_range(0, 9) == 0) ? 2'($urandom) : 2'b00,
              6'($urandom_range(8'h1C, 8'h2B))};
        access(K_IOWR, ra, rd, $urandom_range(1, 3));
      end else if (r < 35) begin
        rd[6] = ($urandom_range(0, 5) == 0);
        access(K_IOWR, {10'd0, SP}, rd, $urandom_range(1, 3));
      end else if (r < 45) begin
        ra = ($urandom_range(0, 1) == 1) ? {10'd0, SP} : 16'($urandom);
        access(K_IORD, ra, rd, $urandom_range(1, 3));
      end else if (r < 85) begin
        ra = {($urandom_range(0, 4) != 0) ? 3'b011 : 3'($urandom),
              13'($urandom)};
        access(K_MEMRD, ra, rd, $urandom_range(1, 3));
      end else if (r < 90) begin
        access(K_MEMWR, 16'($urandom), rd, $urandom_range(1, 3));
      end else if (r < 94) begin
        ra = {3'b011, 5'($urandom), 2'b00,
              6'(VB + 6'($urandom_range(0, 7)))};
        access(K_COLL, ra, rd, 1);
      end else begin
        mode_full = ~mode_full;
      end
      idle($urandom_range(1, 2));
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    idle(8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
